// File: rtl/s2mm_pkg.sv
// rtl/s2mm_pkg.sv - shared types and constants for the S2MM write arbiter
package s2mm_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SIZE_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 64;
endpackage

// File: rtl/s2mm_rr_sel.sv
// rtl/s2mm_rr_sel.sv - two-way round-robin picker holding the most recent owner
module s2mm_rr_sel (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic       grant
);
    logic last_owner_q;
    logic last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (update) begin
            last_owner_d = owner;
        end
        // On a tie the port that did not go last wins; otherwise the lone requester.
        grant = (req[0] && req[1]) ? ~last_owner_q : req[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
endmodule

// File: rtl/s2mm_wr_arb.sv
// rtl/s2mm_wr_arb.sv - round-robin arbiter holding one grant per S2MM write transaction
module s2mm_wr_arb
    import s2mm_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_wreq_valid,
    output logic                  m0_wreq_ready,
    input  logic [ADDR_WIDTH-1:0] m0_wreq_addr,
    input  logic [SIZE_WIDTH-1:0] m0_wreq_size,
    input  logic                  m0_wdata_valid,
    output logic                  m0_wdata_ready,
    input  logic                  m0_wdata_last,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_wresp_valid,
    output logic [1:0]            m0_wresp,
    input  logic                  m1_wreq_valid,
    output logic                  m1_wreq_ready,
    input  logic [ADDR_WIDTH-1:0] m1_wreq_addr,
    input  logic [SIZE_WIDTH-1:0] m1_wreq_size,
    input  logic                  m1_wdata_valid,
    output logic                  m1_wdata_ready,
    input  logic                  m1_wdata_last,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_wresp_valid,
    output logic [1:0]            m1_wresp,
    output logic                  s_wreq_valid,
    input  logic                  s_wreq_ready,
    output logic [ADDR_WIDTH-1:0] s_wreq_addr,
    output logic [SIZE_WIDTH-1:0] s_wreq_size,
    output logic                  s_wdata_valid,
    input  logic                  s_wdata_ready,
    output logic                  s_wdata_last,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wresp_valid,
    input  logic [1:0]            s_wresp,
    output logic                  arb_busy,
    output logic                  arb_owner,
    output logic [7:0]            len_err_cnt
);
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [SIZE_WIDTH-1:0] exp_size_q, exp_size_d;
    logic [SIZE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]            len_err_cnt_q, len_err_cnt_d;
    logic                  rr_grant;
    logic                  rr_update;
    logic [SIZE_WIDTH-1:0] beat_cnt_inc;

    s2mm_rr_sel u_rr_sel (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_wreq_valid, m0_wreq_valid}),
        .update (rr_update),
        .owner  (owner_q),
        .grant  (rr_grant)
    );

    assign beat_cnt_inc = beat_cnt_q + SIZE_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        exp_size_d    = exp_size_q;
        beat_cnt_d    = beat_cnt_q;
        len_err_cnt_d = len_err_cnt_q;
        rr_update     = 1'b0;

        // Data path is a pure mux on the owner; valids and readies are gated by state.
        s_wreq_addr   = owner_q ? m1_wreq_addr  : m0_wreq_addr;
        s_wreq_size   = owner_q ? m1_wreq_size  : m0_wreq_size;
        s_wdata       = owner_q ? m1_wdata      : m0_wdata;
        s_wdata_last  = owner_q ? m1_wdata_last : m0_wdata_last;
        s_wreq_valid  = (state_q == REQ)  && (owner_q ? m1_wreq_valid  : m0_wreq_valid);
        s_wdata_valid = (state_q == DATA) && (owner_q ? m1_wdata_valid : m0_wdata_valid);

        m0_wreq_ready  = (state_q == REQ)  && !owner_q && s_wreq_ready;
        m1_wreq_ready  = (state_q == REQ)  &&  owner_q && s_wreq_ready;
        m0_wdata_ready = (state_q == DATA) && !owner_q && s_wdata_ready;
        m1_wdata_ready = (state_q == DATA) &&  owner_q && s_wdata_ready;
        m0_wresp_valid = (state_q == RESP) && !owner_q && s_wresp_valid;
        m1_wresp_valid = (state_q == RESP) &&  owner_q && s_wresp_valid;
        m0_wresp       = ((state_q == RESP) && !owner_q) ? s_wresp : OKAY;
        m1_wresp       = ((state_q == RESP) &&  owner_q) ? s_wresp : OKAY;

        case (state_q)
            IDLE: begin
                if (m0_wreq_valid || m1_wreq_valid) begin
                    owner_d = rr_grant;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (s_wreq_valid && s_wreq_ready) begin
                    exp_size_d = s_wreq_size;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (s_wdata_valid && s_wdata_ready) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (s_wdata_last) begin
                        // A zero-size request never matches, even if the count wraps to 0.
                        if (((beat_cnt_inc != exp_size_q) || (exp_size_q == '0))
                            && (len_err_cnt_q != 8'hff)) begin
                            len_err_cnt_d = len_err_cnt_q + 8'd1;
                        end
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (s_wresp_valid) begin
                    rr_update = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            exp_size_q    <= '0;
            beat_cnt_q    <= '0;
            len_err_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            exp_size_q    <= exp_size_d;
            beat_cnt_q    <= beat_cnt_d;
            len_err_cnt_q <= len_err_cnt_d;
        end
    end

    assign arb_busy    = (state_q != IDLE);
    assign arb_owner   = owner_q;
    assign len_err_cnt = len_err_cnt_q;
endmodule

// File: doc/s2mm_wr_arb.md
# s2mm_wr_arb

Two-requester round-robin arbiter for the S2MM write channel (request, data, response). It sits between two write sources, such as the test data generator and a second traffic source, and the single downstream write datamover port. The grant is held for a complete transaction: request, then all data beats to last, then response. The block also checks burst length against the requested size.

## Interface
Parameters:
- ADDR_WIDTH, 32, write address width
- SIZE_WIDTH, 16, request size width; size is in data beats
- DATA_WIDTH, 64, write data width

Ports (x = 0, 1 for the two requesters):
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- mx_wreq_valid  in  1  requester x write request valid
- mx_wreq_ready  out  1  request accepted from requester x
- mx_wreq_addr  in  ADDR_WIDTH  request address
- mx_wreq_size  in  SIZE_WIDTH  request beat count
- mx_wdata_valid  in  1  data beat valid
- mx_wdata_ready  out  1  data beat accepted
- mx_wdata_last  in  1  final beat of burst
- mx_wdata  in  DATA_WIDTH  data beat
- mx_wresp_valid  out  1  response strobe to requester x
- mx_wresp  out  2  response code
- s_wreq_valid / s_wreq_ready / s_wreq_addr / s_wreq_size  out/in/out/out  1/1/ADDR_WIDTH/SIZE_WIDTH  downstream request
- s_wdata_valid / s_wdata_ready / s_wdata_last / s_wdata  out/in/out/out  1/1/1/DATA_WIDTH  downstream data
- s_wresp_valid / s_wresp  in/in  1/2  downstream response
- arb_busy  out  1  transaction in progress (state != IDLE)
- arb_owner  out  1  current or most recent grant index
- len_err_cnt  out  8  saturating count of burst-length mismatches

## Operation
- FSM states: IDLE, REQ, DATA, RESP.
- **IDLE**
  - No valid is driven downstream and all mx ready signals are 0.
  - If any mx_wreq_valid is high, register the grant and go to REQ.
  - Both valid: grant the index opposite last_owner. Single valid: grant that index.
  - last_owner resets to 1, so port 0 wins the first tie.
- **REQ**
  - Combinational mux: s_wreq_* = owner's wreq signals; owner's wreq_ready = s_wreq_ready; the non-owner's ready is 0.
  - On transfer (valid and ready both high): latch size into exp_size, clear beat_cnt, go to DATA.
- **DATA**
  - Owner's wdata, valid and last are muxed to s_wdata_*; s_wdata_ready is routed to the owner only.
  - Each transferred beat increments beat_cnt (SIZE_WIDTH bits, wraps).
  - On the transferred beat with last=1: if beat_cnt+1 != exp_size, increment len_err_cnt (saturates at 255); then go to RESP.
  - The burst is always terminated by last, never by the count.
  - exp_size = 0 always flags an error.
- **RESP**
  - mx_wresp_valid[owner] = s_wresp_valid and mx_wresp = s_wresp, combinationally. The non-owner sees valid 0.
  - On s_wresp_valid: last_owner <= owner, go to IDLE.
- s_wresp_valid outside RESP is ignored and not forwarded.
- The non-owner is stalled (ready 0) for the whole transaction; its valids may stay high.
- arb_owner updates on grant and holds through IDLE.

## Timing
- Reset values:
  - State IDLE; arb_busy 0; arb_owner 0; last_owner 1; len_err_cnt 0; beat_cnt 0; exp_size 0.
  - All valid and ready outputs 0; mx_wresp 0; s_wdata/addr/size carry the port-0 mux value.
- Grant latency: request valid in IDLE at cycle t gives REQ at t+1, so s_wreq_valid is visible at t+1.
- Request transfer at t gives DATA at t+1. First beat can transfer at t+1.
- Last beat at t gives RESP at t+1.
- Response at t gives IDLE at t+1. The next grant is registered at t+1, so the request is forwarded at t+2.
- Minimum transaction for one beat is 5 cycles (grant through IDLE).
- Simultaneous valids at grant are resolved by round-robin. Continuously requesting ports alternate strictly.
- rst high mid-transaction: the block returns to reset values on the next edge and the in-flight burst is abandoned. Downstream recovery is out of scope.
- All mux paths are combinational. There are no registers in the data path.

## Structure
- Shared package s2mm_pkg:
  - state enum {IDLE, REQ, DATA, RESP}
  - response code constants OKAY=2'b00, SLVERR=2'b10
  - default widths
- Sub-module s2mm_rr_sel: 2-way round-robin picker holding last_owner, with a grant/update strobe. Everything else stays flat.

## Test plan
- **Single port:** m0 requests addr 0x1000, size 4, sends 4 beats (data 0–3, last on beat 4), s_wresp 0. Required: downstream sees the same addr/size/data; m0_wresp_valid pulses once with 0; len_err_cnt 0; arb_owner 0.
- **Tie after reset:** both request in the same cycle. Required: m0 is served first, then m1. With both re-requesting continuously, the grant order is 0,1,0,1.
- **Length mismatch:** m1 requests size 8 and asserts last on beat 5. Required: len_err_cnt goes 0→1, the FSM still completes, and the response goes to m1 only. A size-0 request with a one-beat burst also increments the count.
- **Backpressure:** s_wdata_ready toggles every cycle during a size-16 burst. Required: exactly 16 beats transfer in order; m1's ready stays 0 throughout.
- **Saturation and stray response:**
  - 260 mismatched bursts. Required: len_err_cnt holds at 255.
  - s_wresp_valid pulsed in IDLE. Required: no mx_wresp_valid, no state change.
- **Mid-burst reset:** rst asserted for 1 cycle during DATA. Required: next cycle all outputs are at reset values. A new m1 request is then granted 1 cycle after rst falls.
